// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
// Requester-side bundle for the two-port SRAM arbiter.
//   req0/req1     request, held high until the matching ack
//   we0/we1       1 = write, 0 = read, stable while req is high
//   addr0/addr1   access address, stable while req is high
//   wdat0/wdat1   write data, stable while req is high
//   ack0/ack1     one-cycle completion pulse
//   rdata         read data, valid in the ack cycle, held until the next read
//   busy          arbiter is not idle
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface sram_arbiter_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdat0;
    logic [7:0] wdat1;
    logic       ack0;
    logic       ack1;
    logic [7:0] rdata;
    logic       busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdat0, wdat1,
        input  ack0, ack1, rdata, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdat0, wdat1,
        output ack0, ack1, rdata, busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Shares one external 8-bit asynchronous SRAM between two requesters
// (port 0: CPU path, port 1: loader/debug DMA). Every access runs
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES clocks) -> DONE -> IDLE with
// registered active-low strobes.
// Parameters:
//   WAIT_CYCLES  ACCESS-phase length in clocks, 1..15
//   PRIO_MODE    0 = round-robin, 1 = fixed priority (port 0 wins)
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   bus          requester bundle (slave side)
//   sram_addr    SRAM address (registered)
//   sram_cen     chip enable, active low
//   sram_wen     write enable, active low
//   sram_oen     output enable, active low
//   sram_dq      bidirectional data, driven only during write accesses
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter bit          PRIO_MODE   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus,
    output logic [7:0]    sram_addr,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic          sram_oen,
    inout  wire  [7:0]    sram_dq
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state_reg, state_next;
    logic       gsel_reg, gsel_next;
    logic       last_grant_reg, last_grant_next;
    logic       we_reg, we_next;
    logic [7:0] addr_reg, addr_next;
    logic [7:0] wdat_reg, wdat_next;
    logic [7:0] rdata_reg, rdata_next;
    logic [7:0] sram_addr_reg, sram_addr_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       cen_reg, cen_next;
    logic       wen_reg, wen_next;
    logic       oen_reg, oen_next;
    logic       dq_oe_reg, dq_oe_next;
    logic       ack0_reg, ack0_next;
    logic       ack1_reg, ack1_next;
    logic       pick;

    // Grant decision for the IDLE cycle. On a tie, round-robin favours the
    // port that did not win last time; last_grant resets to 1 so port 0
    // wins the very first tie.
    always_comb begin
        if (bus.req0 && bus.req1)
            pick = PRIO_MODE ? 1'b0 : ~last_grant_reg;
        else
            pick = bus.req1;
    end

    always_comb begin
        state_next      = state_reg;
        gsel_next       = gsel_reg;
        last_grant_next = last_grant_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdat_next       = wdat_reg;
        rdata_next      = rdata_reg;
        sram_addr_next  = sram_addr_reg;
        cnt_next        = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_next     = SETUP;
                    gsel_next      = pick;
                    we_next        = pick ? bus.we1   : bus.we0;
                    addr_next      = pick ? bus.addr1 : bus.addr0;
                    wdat_next      = pick ? bus.wdat1 : bus.wdat0;
                    sram_addr_next = pick ? bus.addr1 : bus.addr0;
                end
            end
            SETUP: begin
                state_next = ACCESS;
                cnt_next   = CNT_LOAD;
            end
            ACCESS: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                    // SRAM has had oen low for the whole access by now
                    if (!we_reg)
                        rdata_next = sram_dq;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next      = IDLE;
                last_grant_next = gsel_reg;
            end
            default: state_next = IDLE;
        endcase

        // Strobes are decoded from the state being entered so that they
        // leave the block straight from flops, glitch-free.
        cen_next   = 1'b1;
        wen_next   = 1'b1;
        oen_next   = 1'b1;
        dq_oe_next = 1'b0;
        ack0_next  = 1'b0;
        ack1_next  = 1'b0;
        case (state_next)
            SETUP: begin
                cen_next   = 1'b0;
                oen_next   = we_next;
                dq_oe_next = we_next;
            end
            ACCESS: begin
                cen_next   = 1'b0;
                oen_next   = we_next;
                wen_next   = ~we_next;
                dq_oe_next = we_next;
            end
            DONE: begin
                // keep write data on the bus one more cycle for hold time
                dq_oe_next = we_next;
                ack0_next  = ~gsel_next;
                ack1_next  = gsel_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            gsel_reg       <= 1'b0;
            last_grant_reg <= 1'b1;
            we_reg         <= 1'b0;
            addr_reg       <= 8'd0;
            wdat_reg       <= 8'd0;
            rdata_reg      <= 8'd0;
            sram_addr_reg  <= 8'd0;
            cnt_reg        <= 4'd0;
            cen_reg        <= 1'b1;
            wen_reg        <= 1'b1;
            oen_reg        <= 1'b1;
            dq_oe_reg      <= 1'b0;
            ack0_reg       <= 1'b0;
            ack1_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            gsel_reg       <= gsel_next;
            last_grant_reg <= last_grant_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdat_reg       <= wdat_next;
            rdata_reg      <= rdata_next;
            sram_addr_reg  <= sram_addr_next;
            cnt_reg        <= cnt_next;
            cen_reg        <= cen_next;
            wen_reg        <= wen_next;
            oen_reg        <= oen_next;
            dq_oe_reg      <= dq_oe_next;
            ack0_reg       <= ack0_next;
            ack1_reg       <= ack1_next;
        end
    end

    assign sram_addr = sram_addr_reg;
    assign sram_cen  = cen_reg;
    assign sram_wen  = wen_reg;
    assign sram_oen  = oen_reg;
    assign sram_dq   = dq_oe_reg ? wdat_reg : 8'hzz;

    assign bus.ack0  = ack0_reg;
    assign bus.ack1  = ack1_reg;
    assign bus.rdata = rdata_reg;
    assign bus.busy  = (state_reg != IDLE);
endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Three arbiter instances with different parameters, each wired to its own
// SRAM model. A transaction-level model (start cycle + offset arithmetic,
// reference memory) predicts every output each cycle; directed scenarios add
// hand-computed latency, grant-order and data expectations.
//   inst 0: WAIT=1, fixed priority   inst 1: WAIT=3, round-robin
//   inst 2: WAIT=2, round-robin
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int N = 3;

    function automatic int cfg_w(int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit cfg_p(int i);
        return (i == 0);
    endfunction

    function automatic logic [7:0] pat(logic [7:0] a);
        return (a == 8'h12) ? 8'hA5 : 8'(a * 8'd13 + 8'd7);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst_d, req0, req1, we0, we1;
    logic [7:0]   addr0 [N], addr1 [N], wdat0 [N], wdat1 [N];
    logic [N-1:0] ack0_w, ack1_w, busy_w, cen_w, wen_w, oen_w;
    logic [7:0]   saddr_w [N], rdata_w [N], dq_w [N];
    bit           sram_init;
    logic [7:0]   mem_probe;

    for (genvar gi = 0; gi < N; gi++) begin : g
        sram_arbiter_if bus ();
        wire  [7:0] dq;
        logic [7:0] saddr;
        logic       cen, wen, oen;
        logic [7:0] mem [256];

        assign bus.req0  = req0[gi];
        assign bus.req1  = req1[gi];
        assign bus.we0   = we0[gi];
        assign bus.we1   = we1[gi];
        assign bus.addr0 = addr0[gi];
        assign bus.addr1 = addr1[gi];
        assign bus.wdat0 = wdat0[gi];
        assign bus.wdat1 = wdat1[gi];

        sram_arbiter #(.WAIT_CYCLES(cfg_w(gi)), .PRIO_MODE(cfg_p(gi))) dut (
            .clk      (clk),
            .rst      (rst_d[gi]),
            .bus      (bus),
            .sram_addr(saddr),
            .sram_cen (cen),
            .sram_wen (wen),
            .sram_oen (oen),
            .sram_dq  (dq)
        );

        // undriven bus floats to 0xFF so stray drive by the arbiter is visible
        for (genvar b = 0; b < 8; b++) begin : pu
            pullup (dq[b]);
        end
        assign dq = (!cen && !oen) ? mem[saddr] : 8'hzz;

        always @(posedge clk) begin
            if (sram_init) begin
                for (int a = 0; a < 256; a++) mem[a] <= pat(8'(a));
            end else if (!cen && !wen) begin
                mem[saddr] <= dq;
            end
        end

        assign ack0_w[gi]  = bus.ack0;
        assign ack1_w[gi]  = bus.ack1;
        assign busy_w[gi]  = bus.busy;
        assign rdata_w[gi] = bus.rdata;
        assign cen_w[gi]   = cen;
        assign wen_w[gi]   = wen;
        assign oen_w[gi]   = oen;
        assign saddr_w[gi] = saddr;
        assign dq_w[gi]    = dq;
    end

    assign mem_probe = g[1].mem[8'h40];

    // ---------------- model state ----------------
    int         n_vec = 0, n_fail = 0, cyc = 0;
    bit         m_act [N], m_port [N], m_we [N], m_last [N];
    int         m_off [N];
    logic [7:0] m_addr [N], m_wdat [N], m_rdata [N], m_saddr [N];
    logic [7:0] m_mem [N][256];
    bit         p_rst [N], p_r0 [N], p_r1 [N], p_we0 [N], p_we1 [N];
    logic [7:0] p_a0 [N], p_a1 [N], p_d0 [N], p_d1 [N];
    bit [N-1:0] s_ack0, s_ack1, s_oen, s_wen;
    logic [7:0] s_dq [N], s_rdata [N];

    task automatic chk(string name, int i, logic [7:0] got, logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got %h want %h", name, i, cyc, got, want);
        end
    endtask

    task automatic model_reset(int i);
        m_act[i]   = 1'b0;
        m_off[i]   = 0;
        m_last[i]  = 1'b1;
        m_rdata[i] = 8'd0;
        m_saddr[i] = 8'd0;
    endtask

    // One rising edge of instance i, using the inputs that edge sampled.
    // A transaction occupies offsets 0 (SETUP), 1..W (ACCESS), W+1 (DONE);
    // the edge after DONE returns to idle without looking at requests.
    task automatic model_edge(int i);
        int w;
        bit sel;
        w = cfg_w(i);
        if (!p_rst[i]) return;
        if (m_act[i]) begin
            m_off[i]++;
            if (m_off[i] == w + 1) begin
                if (m_we[i]) m_mem[i][m_addr[i]] = m_wdat[i];
                else         m_rdata[i] = m_mem[i][m_addr[i]];
            end else if (m_off[i] == w + 2) begin
                m_act[i]  = 1'b0;
                m_last[i] = m_port[i];
            end
        end else if (p_r0[i] || p_r1[i]) begin
            if (p_r0[i] && p_r1[i]) sel = cfg_p(i) ? 1'b0 : !m_last[i];
            else                    sel = p_r1[i];
            m_port[i]  = sel;
            m_we[i]    = sel ? p_we1[i] : p_we0[i];
            m_addr[i]  = sel ? p_a1[i]  : p_a0[i];
            m_wdat[i]  = sel ? p_d1[i]  : p_d0[i];
            m_saddr[i] = m_addr[i];
            m_act[i]   = 1'b1;
            m_off[i]   = 0;
        end
    endtask

    task automatic compare(int i);
        int w;
        bit su_ac, ac, dn;
        logic [7:0] exp_dq;
        w     = cfg_w(i);
        su_ac = m_act[i] && (m_off[i] <= w);
        ac    = m_act[i] && (m_off[i] >= 1) && (m_off[i] <= w);
        dn    = m_act[i] && (m_off[i] == w + 1);
        if (m_act[i] && m_we[i]) exp_dq = m_wdat[i];
        else if (su_ac)          exp_dq = m_mem[i][m_addr[i]];
        else                     exp_dq = 8'hFF;
        chk("cen",   i, 8'(cen_w[i]),  8'(!su_ac));
        chk("oen",   i, 8'(oen_w[i]),  8'(!(su_ac && !m_we[i])));
        chk("wen",   i, 8'(wen_w[i]),  8'(!(ac && m_we[i])));
        chk("ack0",  i, 8'(ack0_w[i]), 8'(dn && !m_port[i]));
        chk("ack1",  i, 8'(ack1_w[i]), 8'(dn && m_port[i]));
        chk("busy",  i, 8'(busy_w[i]), 8'(m_act[i]));
        chk("saddr", i, saddr_w[i], m_saddr[i]);
        chk("rdata", i, rdata_w[i], m_rdata[i]);
        chk("dq",    i, dq_w[i], exp_dq);
        chk("wen_oen_excl", i, 8'(wen_w[i] | oen_w[i]), 8'd1);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            model_edge(i);
            if (!rst_d[i]) model_reset(i);
            s_ack0[i]  = ack0_w[i];
            s_ack1[i]  = ack1_w[i];
            s_oen[i]   = oen_w[i];
            s_wen[i]   = wen_w[i];
            s_dq[i]    = dq_w[i];
            s_rdata[i] = rdata_w[i];
            compare(i);
            p_rst[i] = rst_d[i];
            p_r0[i]  = req0[i];
            p_r1[i]  = req1[i];
            p_we0[i] = we0[i];
            p_we1[i] = we1[i];
            p_a0[i]  = addr0[i];
            p_a1[i]  = addr1[i];
            p_d0[i]  = wdat0[i];
            p_d1[i]  = wdat1[i];
        end
        @(posedge clk);
        #2;
    endtask

    // Runs until port's ack; lat = edges from the sampling edge to the edge
    // that first sees ack high. Also counts strobe-low and dq==dval cycles.
    task automatic run_txn(input int i, input bit port, input logic [7:0] dval,
                           output int lat, output int n_oen, output int n_wen,
                           output int n_dq, output int other, output logic [7:0] rd);
        lat = -1; n_oen = 0; n_wen = 0; n_dq = 0; other = 0; rd = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (!s_oen[i]) n_oen++;
            if (!s_wen[i]) n_wen++;
            if (s_dq[i] == dval) n_dq++;
            if (port ? s_ack0[i] : s_ack1[i]) other++;
            if (port ? s_ack1[i] : s_ack0[i]) begin
                lat = k - 1;
                rd  = s_rdata[i];
                break;
            end
        end
    endtask

    task automatic wait_any(input int i, output int port, output int at, output int ovl);
        port = -1; at = -1; ovl = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (s_ack0[i] && s_ack1[i]) ovl = 1;
            if (s_ack0[i] || s_ack1[i]) begin
                port = s_ack1[i] ? 1 : 0;
                at   = cyc;
                break;
            end
        end
    endtask

    initial begin
        int lat, n_oen, n_wen, n_dq, other, port, at, prev, ovl;
        logic [7:0] rd;
        bit exp_g [4];
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst_d = '0; req0 = '0; req1 = '0; we0 = '0; we1 = '0;
        sram_init = 1'b1;
        for (int i = 0; i < N; i++) begin
            addr0[i] = 8'h00; addr1[i] = 8'h00; wdat0[i] = 8'h00; wdat1[i] = 8'h00;
            for (int a = 0; a < 256; a++) m_mem[i][a] = pat(8'(a));
            model_reset(i);
        end
        repeat (3) step();
        sram_init = 1'b0;
        repeat (2) step();
        rst_d = '1;
        repeat (2) step();

        // 1: read port 0, WAIT=1, SRAM[0x12]=0xA5
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 8'h12; wdat0[0] = 8'h77;
        run_txn(0, 1'b0, 8'h77, lat, n_oen, n_wen, n_dq, other, rd);
        req0[0] = 1'b0;
        chk("t1_latency", 0, 8'(lat), 8'd3);
        chk("t1_oen_low", 0, 8'(n_oen), 8'd2);
        chk("t1_wen_low", 0, 8'(n_wen), 8'd0);
        chk("t1_ack1",    0, 8'(other), 8'd0);
        chk("t1_rdata",   0, rd, 8'hA5);
        repeat (2) step();

        // 2: write port 1, addr 0x40 data 0x3C, WAIT=3
        req1[1] = 1'b1; we1[1] = 1'b1; addr1[1] = 8'h40; wdat1[1] = 8'h3C;
        run_txn(1, 1'b1, 8'h3C, lat, n_oen, n_wen, n_dq, other, rd);
        req1[1] = 1'b0;
        chk("t2_latency", 1, 8'(lat), 8'd5);
        chk("t2_wen_low", 1, 8'(n_wen), 8'd3);
        chk("t2_oen_low", 1, 8'(n_oen), 8'd0);
        chk("t2_dq_cyc",  1, 8'(n_dq), 8'd5);
        chk("t2_ack0",    1, 8'(other), 8'd0);
        step();
        chk("t2_sram",    1, mem_probe, 8'h3C);
        step();

        // 3: both held, round-robin, WAIT=2: grants 0,1,0,1, acks every
        //    IDLE+SETUP+2*ACCESS+DONE = 5 clocks
        req0[2] = 1'b1; addr0[2] = 8'h20; wdat0[2] = 8'h11;
        req1[2] = 1'b1; addr1[2] = 8'h21; wdat1[2] = 8'h22;
        prev = 0;
        for (int j = 0; j < 4; j++) begin
            wait_any(2, port, at, ovl);
            chk("t3_grant",   2, 8'(port), 8'(exp_g[j]));
            chk("t3_overlap", 2, 8'(ovl), 8'd0);
            if (j > 0) chk("t3_gap", 2, 8'(at - prev), 8'd5);
            prev = at;
        end
        req0[2] = 1'b0; req1[2] = 1'b0;
        repeat (2) step();

        // 4: both held, fixed priority, WAIT=1: port 0 every time, port 1
        //    only once req0 drops
        req0[0] = 1'b1; addr0[0] = 8'h30; wdat0[0] = 8'h44;
        req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 8'h31; wdat1[0] = 8'h55;
        prev = 0;
        for (int j = 0; j < 3; j++) begin
            wait_any(0, port, at, ovl);
            chk("t4_grant", 0, 8'(port), 8'd0);
            if (j > 0) chk("t4_gap", 0, 8'(at - prev), 8'd4);
            prev = at;
        end
        req0[0] = 1'b0;
        wait_any(0, port, at, ovl);
        chk("t4_port1",   0, 8'(port), 8'd1);
        chk("t4_overlap", 0, 8'(ovl), 8'd0);
        req1[0] = 1'b0;
        repeat (2) step();

        // 5: reset during ACCESS of a write on inst 1
        req0[1] = 1'b1; we0[1] = 1'b1; addr0[1] = 8'h55; wdat0[1] = 8'h99;
        step();                 // sampling edge -> SETUP
        step();                 // -> ACCESS
        rst_d[1] = 1'b0;
        #1;
        chk("t5_cen",  1, 8'(cen_w[1]), 8'd1);
        chk("t5_wen",  1, 8'(wen_w[1]), 8'd1);
        chk("t5_oen",  1, 8'(oen_w[1]), 8'd1);
        chk("t5_dq",   1, dq_w[1], 8'hFF);
        chk("t5_busy", 1, 8'(busy_w[1]), 8'd0);
        req0[1] = 1'b0; we0[1] = 1'b0;
        repeat (2) step();
        rst_d[1] = 1'b1;
        step();
        req0[1] = 1'b1; addr0[1] = 8'h40; wdat0[1] = 8'h66;
        run_txn(1, 1'b0, 8'h66, lat, n_oen, n_wen, n_dq, other, rd);
        req0[1] = 1'b0;
        chk("t5_latency", 1, 8'(lat), 8'd5);
        chk("t5_rdata",   1, rd, 8'h3C);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
